// File: rtl/fifo_mon_pkg.sv
// Shared definitions for the FIFO pair recorder: record field positions,
// recorder state encoding and the pair scenario codes read by the sizing monitor.
package fifo_mon_pkg;

  localparam int WB_BIT  = 63;
  localparam int RB_BIT  = 31;
  localparam int LEN_MSB = 62;
  localparam int LEN_LSB = 32;
  localparam int ST_MSB  = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    PAIR_FREE         = 3'd0,
    PAIR_WR_BLOCKED   = 3'd1,
    PAIR_RD_BLOCKED   = 3'd2,
    PAIR_BOTH_BLOCKED = 3'd3,
    PAIR_WR_ONLY      = 3'd4,
    PAIR_RD_ONLY      = 3'd5,
    PAIR_IDLE         = 3'd6
  } pair_scn_e;

  function automatic logic [63:0] make_rec(input logic [1:0] cur,
                                           input logic [30:0] len,
                                           input logic [30:0] st);
    logic [63:0] r;
    r = '0;
    r[WB_BIT]          = cur[1];
    r[LEN_MSB:LEN_LSB] = len;
    r[RB_BIT]          = cur[0];
    r[ST_MSB:0]        = st;
    return r;
  endfunction

endpackage

// File: rtl/fifo_pair_obuf.sv
// First-word fall-through record buffer; a push while full is accepted only
// when a pop frees a slot in the same cycle.
module fifo_pair_obuf #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fifo_pair_recorder.sv
// Observes one FIFO's handshakes, run-length encodes the {wr_blocked, rd_blocked}
// pair each cycle and streams the records out, tracking max occupancy and drops.
module fifo_pair_recorder
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH_W    = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               finish,
  input  logic               wr_req,
  input  logic               full,
  input  logic               rd_req,
  input  logic               empty,
  output logic [63:0]        rec_data,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [15:0]        pair_cnt,
  output logic [DEPTH_W-1:0] max_depth,
  output logic [15:0]        drop_cnt,
  output logic               overflow,
  output logic               done,
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic [DEPTH_W-1:0] occ_q, occ_d, max_q, max_d;
  logic [30:0]        cyc_q, cyc_d, len_q, len_d, st_q, st_d;
  logic [1:0]         cur_q, cur_d;
  logic               open_q, open_d, flush_first_q, flush_first_d;
  logic [15:0]        pair_q, pair_d, drop_q, drop_d;
  logic               ovf_q, ovf_d;

  logic        wb, rb, wr_fire, rd_fire;
  logic [1:0]  now;
  logic        emit, push_ok, pop, clr;
  logic [63:0] emit_rec;
  logic        ob_full, ob_empty;

  assign wb      = wr_req & full;
  assign rb      = rd_req & empty;
  assign wr_fire = wr_req & ~full;
  assign rd_fire = rd_req & ~empty;
  assign now     = {wb, rb};
  assign pop     = ~ob_empty & rec_ready;
  assign push_ok = emit & (~ob_full | pop);

  // Valid/ready: a record transfers on any cycle with rec_valid & rec_ready;
  // rec_data holds its value until that happens.
  fifo_pair_obuf #(.W(64), .DEPTH(OBUF_DEPTH)) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push_ok),
    .push_data (emit_rec),
    .pop       (pop),
    .rd_data   (rec_data),
    .full      (ob_full),
    .empty     (ob_empty)
  );

  always_comb begin
    state_d       = state_q;
    occ_d         = occ_q;
    max_d         = (occ_q > max_q) ? occ_q : max_q;
    cyc_d         = cyc_q;
    len_d         = len_q;
    st_d          = st_q;
    cur_d         = cur_q;
    open_d        = open_q;
    flush_first_d = flush_first_q;
    pair_d        = pair_q;
    drop_d        = drop_q;
    ovf_d         = ovf_q;
    emit          = 1'b0;
    emit_rec      = '0;
    clr           = 1'b0;

    if (start) begin
      // Start from any state restarts; an open run is discarded unemitted.
      clr           = 1'b1;
      state_d       = RUN;
      occ_d         = '0;
      max_d         = '0;
      cyc_d         = '0;
      open_d        = 1'b0;
      flush_first_d = 1'b0;
      pair_d        = '0;
      drop_d        = '0;
      ovf_d         = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (wr_fire && !rd_fire && occ_q != '1)       occ_d = occ_q + DEPTH_W'(1);
          else if (rd_fire && !wr_fire && occ_q != '0)  occ_d = occ_q - DEPTH_W'(1);
          cyc_d = cyc_q + 31'd1;
          if (!open_q) begin
            cur_d  = now;
            len_d  = 31'd1;
            st_d   = cyc_q;
            open_d = 1'b1;
          end else if (now == cur_q && len_q != '1) begin
            len_d = len_q + 31'd1;
          end else begin
            emit     = 1'b1;
            emit_rec = make_rec(cur_q, len_q, st_q);
            cur_d    = now;
            len_d    = 31'd1;
            st_d     = cyc_q;
          end
          if (finish) begin
            state_d       = FLUSH;
            flush_first_d = 1'b1;
          end
        end
        FLUSH: begin
          if (flush_first_q) begin
            emit          = 1'b1;
            emit_rec      = make_rec(cur_q, len_q, st_q);
            flush_first_d = 1'b0;
            open_d        = 1'b0;
          end else if (ob_empty) begin
            state_d = DONE;
          end
        end
        default: ;
      endcase

      if (push_ok && pair_q != 16'hFFFF) pair_d = pair_q + 16'd1;
      if (emit && !push_ok) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      occ_q         <= '0;
      max_q         <= '0;
      cyc_q         <= '0;
      len_q         <= '0;
      st_q          <= '0;
      cur_q         <= '0;
      open_q        <= 1'b0;
      flush_first_q <= 1'b0;
      pair_q        <= '0;
      drop_q        <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      occ_q         <= occ_d;
      max_q         <= max_d;
      cyc_q         <= cyc_d;
      len_q         <= len_d;
      st_q          <= st_d;
      cur_q         <= cur_d;
      open_q        <= open_d;
      flush_first_q <= flush_first_d;
      pair_q        <= pair_d;
      drop_q        <= drop_d;
      ovf_q         <= ovf_d;
    end
  end

  assign rec_valid = ~ob_empty;
  assign pair_cnt  = pair_q;
  assign max_depth = max_q;
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_pair_recorder.sv
// Directed bench for fifo_pair_recorder: hand-computed records, counters and
// state checks across pass-through, blocking, occupancy, drops, restart and reset.
module tb_fifo_pair_recorder;
  import fifo_mon_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, finish = 1'b0;
  logic        wr_req = 1'b0, full = 1'b0, rd_req = 1'b0, empty = 1'b0;
  logic        rec_ready = 1'b0;
  logic [63:0] rec_data;
  logic        rec_valid;
  logic [15:0] pair_cnt, drop_cnt;
  logic [15:0] max_depth;
  logic        overflow, done;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];

  fifo_pair_recorder #(.DEPTH_W(16), .OBUF_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .finish    (finish),
    .wr_req    (wr_req),
    .full      (full),
    .rd_req    (rd_req),
    .empty     (empty),
    .rec_data  (rec_data),
    .rec_valid (rec_valid),
    .rec_ready (rec_ready),
    .pair_cnt  (pair_cnt),
    .max_depth (max_depth),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && rec_valid && rec_ready) got_q.push_back(rec_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic w, input logic f, input logic r, input logic e);
    wr_req = w; full = f; rd_req = r; empty = e;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_cycles(input int n, input logic fin_last);
    for (int i = 0; i < n; i++) begin
      finish = fin_last && (i == n - 1);
      tick();
    end
    finish = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_records(input string tag);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_valid", 64'(rec_valid), 64'd0);
    check("rst_pair", 64'(pair_cnt), 64'd0);
    check("rst_max", 64'(max_depth), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;
    tick();

    // 1. Pass-through: 10 unblocked cycles, both sides firing
    rec_ready = 1'b1;
    do_start();
    check("t1_state_run", 64'(dbg_state), 64'(RUN));
    set_in(1, 0, 1, 0);
    run_cycles(10, 1'b1);
    set_in(0, 0, 0, 0);
    check("t1_state_flush", 64'(dbg_state), 64'(FLUSH));
    wait_done(20);
    exp_q.push_back(64'h0000000A_00000000);
    check_records("t1_rec");
    check("t1_pair", 64'(pair_cnt), 64'd1);
    check("t1_max", 64'(max_depth), 64'd0);

    // 2. Write blocked for 3 cycles, then read blocked for 2
    do_start();
    set_in(1, 1, 0, 0);
    run_cycles(3, 1'b0);
    set_in(0, 0, 1, 1);
    run_cycles(2, 1'b1);
    set_in(0, 0, 0, 0);
    wait_done(20);
    exp_q.push_back(64'h80000003_00000000);
    exp_q.push_back(64'h00000002_80000003);
    check_records("t2_rec");
    check("t2_pair", 64'(pair_cnt), 64'd2);

    // 3. Occupancy: floor at 0, climb to 5, hold on dual fire, drain to 2, climb to 6
    do_start();
    set_in(0, 0, 1, 0); run_cycles(2, 1'b0);
    set_in(1, 0, 0, 0); run_cycles(5, 1'b0);
    set_in(1, 0, 1, 0); run_cycles(2, 1'b0);
    set_in(0, 0, 1, 0); run_cycles(3, 1'b0);
    set_in(0, 0, 0, 0); run_cycles(2, 1'b0);
    check("t3_max_mid", 64'(max_depth), 64'd5);
    set_in(1, 0, 0, 0); run_cycles(4, 1'b1);
    set_in(0, 0, 0, 0);
    wait_done(20);
    check("t3_max_end", 64'(max_depth), 64'd6);
    exp_q.push_back(64'h00000012_00000000);
    check_records("t3_rec");

    // 4. Backpressure: pair toggles each cycle, consumer stalled
    rec_ready = 1'b0;
    do_start();
    for (int i = 0; i < 8; i++) begin
      set_in(1, (i % 2 == 1), 0, 1);
      finish = (i == 7);
      tick();
    end
    finish = 1'b0;
    set_in(0, 0, 0, 0);
    check("t4_drop_pre", 64'(drop_cnt), 64'd3);
    check("t4_pair", 64'(pair_cnt), 64'd4);
    check("t4_ovf", 64'(overflow), 64'd1);
    check("t4_valid", 64'(rec_valid), 64'd1);
    tick();
    check("t4_drop_post", 64'(drop_cnt), 64'd4);
    tick(); tick(); tick();
    check("t4_not_done", 64'(done), 64'd0);
    check("t4_state_flush", 64'(dbg_state), 64'(FLUSH));
    check("t4_head_hold", rec_data, 64'h00000001_00000000);
    rec_ready = 1'b1;
    wait_done(20);
    exp_q.push_back(64'h00000001_00000000);
    exp_q.push_back(64'h80000001_00000001);
    exp_q.push_back(64'h00000001_00000002);
    exp_q.push_back(64'h80000001_00000003);
    check_records("t4_rec");
    check("t4_pair_end", 64'(pair_cnt), 64'd4);

    // 6a. Restart from DONE clears statistics
    do_start();
    check("t6a_pair", 64'(pair_cnt), 64'd0);
    check("t6a_drop", 64'(drop_cnt), 64'd0);
    check("t6a_ovf", 64'(overflow), 64'd0);
    check("t6a_max", 64'(max_depth), 64'd0);
    check("t6a_state", 64'(dbg_state), 64'(RUN));
    set_in(0, 0, 1, 1);
    run_cycles(2, 1'b1);
    set_in(0, 0, 0, 0);
    wait_done(20);
    exp_q.push_back(64'h00000002_80000000);
    check_records("t6a_rec");

    // 6b. Restart mid-run discards buffered records and the open run
    rec_ready = 1'b0;
    do_start();
    set_in(1, 1, 0, 0); run_cycles(2, 1'b0);
    set_in(0, 0, 0, 0); run_cycles(2, 1'b0);
    check("t6b_pair_pre", 64'(pair_cnt), 64'd1);
    check("t6b_valid_pre", 64'(rec_valid), 64'd1);
    do_start();
    check("t6b_pair_clr", 64'(pair_cnt), 64'd0);
    check("t6b_valid_clr", 64'(rec_valid), 64'd0);
    check("t6b_state", 64'(dbg_state), 64'(RUN));
    rec_ready = 1'b1;
    set_in(0, 0, 1, 1);
    run_cycles(2, 1'b1);
    set_in(0, 0, 0, 0);
    wait_done(20);
    exp_q.push_back(64'h00000002_80000000);
    check_records("t6b_rec");

    // 5. Asynchronous reset between edges with two records buffered
    rec_ready = 1'b0;
    do_start();
    set_in(1, 1, 0, 0); run_cycles(1, 1'b0);
    set_in(0, 0, 0, 0); run_cycles(1, 1'b0);
    set_in(1, 1, 0, 0); run_cycles(2, 1'b0);
    check("t5_pair_pre", 64'(pair_cnt), 64'd2);
    check("t5_valid_pre", 64'(rec_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_valid_rst", 64'(rec_valid), 64'd0);
    check("t5_pair_rst", 64'(pair_cnt), 64'd0);
    check("t5_max_rst", 64'(max_depth), 64'd0);
    check("t5_drop_rst", 64'(drop_cnt), 64'd0);
    check("t5_state_rst", 64'(dbg_state), 64'(IDLE));
    tick();
    rst = 1'b1;
    rec_ready = 1'b1;
    set_in(0, 0, 1, 1);
    run_cycles(4, 1'b0);
    check("t5_valid_after", 64'(rec_valid), 64'd0);
    check("t5_state_after", 64'(dbg_state), 64'(IDLE));
    check("t5_got_none", 64'(got_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
